// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter/sequencer for a single-port
// synchronous BRAM with 1-cycle registered read latency.
`default_nettype none

module mem_arbiter #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 Req_A,
    input  logic                 Wr_A,
    input  logic [AddrWidth-1:0] Addr_A,
    input  logic [DataWidth-1:0] WData_A,
    output logic                 Ack_A,
    output logic [DataWidth-1:0] RData_A,
    input  logic                 Req_B,
    input  logic                 Wr_B,
    input  logic [AddrWidth-1:0] Addr_B,
    input  logic [DataWidth-1:0] WData_B,
    output logic                 Ack_B,
    output logic [DataWidth-1:0] RData_B,
    output logic [AddrWidth-1:0] Mem_Address,
    output logic [DataWidth-1:0] Mem_DIn,
    output logic                 Mem_Write_EN,
    input  logic [DataWidth-1:0] Mem_DOut,
    output logic                 Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic                  last_grant_q, last_grant_d;
    logic [AddrWidth-1:0]  addr_q, addr_d;
    logic [DataWidth-1:0]  din_q, din_d;
    logic                  we_q, we_d;
    logic                  ack_a_q, ack_a_d;
    logic                  ack_b_q, ack_b_d;
    logic                  grant_b;
    logic                  grant_wr;

    // B wins if it is alone, or if both ask and A was served last.
    assign grant_b  = Req_B && (!Req_A || (last_grant_q == OWN_A));
    assign grant_wr = grant_b ? Wr_B : Wr_A;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        din_d        = din_q;
        we_d         = we_q;
        ack_a_d      = ack_a_q;
        ack_b_d      = ack_b_q;
        case (state_q)
            IDLE: begin
                we_d = 1'b0;
                if (Req_A || Req_B) begin
                    owner_d      = grant_b;
                    wr_d         = grant_wr;
                    last_grant_d = grant_b;
                    addr_d       = grant_b ? Addr_B : Addr_A;
                    din_d        = grant_b ? WData_B : WData_A;
                    we_d         = grant_wr;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                we_d    = 1'b0;
                ack_a_d = (owner_q == OWN_A);
                ack_b_d = (owner_q == OWN_B);
                state_d = RESP;
            end
            RESP: begin
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                we_d    = 1'b0;
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q      <= IDLE;
            owner_q      <= OWN_A;
            wr_q         <= 1'b0;
            last_grant_q <= OWN_B;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            we_q         <= we_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    // Memory DOut is valid only in RESP, which is exactly when Ack is high.
    assign RData_A      = (ack_a_q && !wr_q) ? Mem_DOut : '0;
    assign RData_B      = (ack_b_q && !wr_q) ? Mem_DOut : '0;
    assign Ack_A        = ack_a_q;
    assign Ack_B        = ack_b_q;
    assign Mem_Address  = addr_q;
    assign Mem_DIn      = din_q;
    assign Mem_Write_EN = we_q;
    assign Busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions plus
// hand-written reset, early-drop and idle sequences against a BRAM model.
`default_nettype none

module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        Req_A = 1'b0, Wr_A = 1'b0;
    logic [7:0]  Addr_A = '0;
    logic [15:0] WData_A = '0;
    logic        Ack_A;
    logic [15:0] RData_A;
    logic        Req_B = 1'b0, Wr_B = 1'b0;
    logic [7:0]  Addr_B = '0;
    logic [15:0] WData_B = '0;
    logic        Ack_B;
    logic [15:0] RData_B;
    logic [7:0]  Mem_Address;
    logic [15:0] Mem_DIn;
    logic        Mem_Write_EN;
    logic [15:0] Mem_DOut;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.AddrWidth(8), .DataWidth(16)) dut (
        .Clk(Clk), .Reset_N(Reset_N),
        .Req_A(Req_A), .Wr_A(Wr_A), .Addr_A(Addr_A), .WData_A(WData_A),
        .Ack_A(Ack_A), .RData_A(RData_A),
        .Req_B(Req_B), .Wr_B(Wr_B), .Addr_B(Addr_B), .WData_B(WData_B),
        .Ack_B(Ack_B), .RData_B(RData_B),
        .Mem_Address(Mem_Address), .Mem_DIn(Mem_DIn),
        .Mem_Write_EN(Mem_Write_EN), .Mem_DOut(Mem_DOut), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // 256 x 16 single-port BRAM, registered read output
    logic [15:0] mem [256];
    always @(posedge Clk) begin
        if (Mem_Write_EN) mem[Mem_Address] <= Mem_DIn;
        Mem_DOut <= mem[Mem_Address];
    end

    typedef struct {
        logic        req_a, wr_a;
        logic [7:0]  addr_a;
        logic [15:0] wd_a;
        logic        req_b, wr_b;
        logic [7:0]  addr_b;
        logic [15:0] wd_b;
        logic        e_busy, e_we;
        logic [7:0]  e_addr;
        logic        e_ack_a;
        logic [15:0] e_rd_a;
        logic        e_ack_b;
        logic [15:0] e_rd_b;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One transaction = 3 rows (E0, E1, E2), inputs held for all three.
    task automatic add_txn(input logic ra, input logic wa, input logic [7:0] aa, input logic [15:0] da,
                           input logic rb, input logic wb, input logic [7:0] ab, input logic [15:0] db,
                           input logic own_b, input logic [7:0] e_addr, input logic e_we,
                           input logic [15:0] e_rd);
        vec_t v;
        v.req_a = ra; v.wr_a = wa; v.addr_a = aa; v.wd_a = da;
        v.req_b = rb; v.wr_b = wb; v.addr_b = ab; v.wd_b = db;
        v.e_addr = e_addr;
        v.e_busy = 1'b1; v.e_we = e_we;
        v.e_ack_a = 1'b0; v.e_rd_a = '0; v.e_ack_b = 1'b0; v.e_rd_b = '0;
        vecs.push_back(v);
        v.e_we = 1'b0;
        v.e_ack_a = !own_b; v.e_rd_a = own_b ? 16'h0 : e_rd;
        v.e_ack_b = own_b;  v.e_rd_b = own_b ? e_rd : 16'h0;
        vecs.push_back(v);
        v.e_busy = 1'b0;
        v.e_ack_a = 1'b0; v.e_rd_a = '0; v.e_ack_b = 1'b0; v.e_rd_b = '0;
        vecs.push_back(v);
    endtask

    initial begin
        // A write 0x10<-BEEF, A read 0x10
        add_txn(1, 1, 8'h10, 16'hBEEF, 0, 0, 8'h00, 16'h0,    0, 8'h10, 1, 16'h0);
        add_txn(1, 0, 8'h10, 16'h0,    0, 0, 8'h00, 16'h0,    0, 8'h10, 0, 16'hBEEF);
        // preload: A writes 0x01, B writes 0x00 (leaves Last_Grant = B)
        add_txn(1, 1, 8'h01, 16'h2222, 0, 0, 8'h00, 16'h0,    0, 8'h01, 1, 16'h0);
        add_txn(0, 0, 8'h00, 16'h0,    1, 1, 8'h00, 16'h1111, 1, 8'h00, 1, 16'h0);
        // contention: both reading, grants alternate A, B, A, B
        add_txn(1, 0, 8'h00, 16'h0,    1, 0, 8'h01, 16'h0,    0, 8'h00, 0, 16'h1111);
        add_txn(1, 0, 8'h00, 16'h0,    1, 0, 8'h01, 16'h0,    1, 8'h01, 0, 16'h2222);
        add_txn(1, 0, 8'h00, 16'h0,    1, 0, 8'h01, 16'h0,    0, 8'h00, 0, 16'h1111);
        add_txn(1, 0, 8'h00, 16'h0,    1, 0, 8'h01, 16'h0,    1, 8'h01, 0, 16'h2222);
        // cross-requester coherency at the top address
        add_txn(0, 0, 8'h00, 16'h0,    1, 1, 8'hFF, 16'h1234, 1, 8'hFF, 1, 16'h0);
        add_txn(1, 0, 8'hFF, 16'h0,    0, 0, 8'h00, 16'h0,    0, 8'hFF, 0, 16'h1234);

        // reset state, before any clock edge
        #2;
        chk("rst_busy", Busy, 0);
        chk("rst_we", Mem_Write_EN, 0);
        chk("rst_addr", Mem_Address, 0);
        chk("rst_din", Mem_DIn, 0);
        chk("rst_acks", {Ack_A, Ack_B}, 0);
        chk("rst_rdata", {RData_A, RData_B}, 0);
        step();
        step();
        Reset_N = 1'b1;

        foreach (vecs[i]) begin
            Req_A = vecs[i].req_a; Wr_A = vecs[i].wr_a; Addr_A = vecs[i].addr_a; WData_A = vecs[i].wd_a;
            Req_B = vecs[i].req_b; Wr_B = vecs[i].wr_b; Addr_B = vecs[i].addr_b; WData_B = vecs[i].wd_b;
            step();
            chk($sformatf("v%0d_busy", i), Busy, vecs[i].e_busy);
            chk($sformatf("v%0d_we", i), Mem_Write_EN, vecs[i].e_we);
            chk($sformatf("v%0d_addr", i), Mem_Address, vecs[i].e_addr);
            chk($sformatf("v%0d_ack_a", i), Ack_A, vecs[i].e_ack_a);
            chk($sformatf("v%0d_rd_a", i), RData_A, vecs[i].e_rd_a);
            chk($sformatf("v%0d_ack_b", i), Ack_B, vecs[i].e_ack_b);
            chk($sformatf("v%0d_rd_b", i), RData_B, vecs[i].e_rd_b);
        end
        Req_A = 1'b0; Req_B = 1'b0;

        // early Req drop: one Ack, no follow-on transaction
        Req_A = 1'b1; Wr_A = 1'b0; Addr_A = 8'h10;
        step();
        chk("drop_grant_busy", Busy, 1);
        chk("drop_grant_addr", Mem_Address, 8'h10);
        Req_A = 1'b0;
        step();
        chk("drop_ack", Ack_A, 1);
        chk("drop_rdata", RData_A, 16'hBEEF);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("drop_after%0d", k), {Busy, Ack_A, Ack_B}, 3'b000);
        end

        // idle hold
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("idle%0d", k), {Busy, Mem_Write_EN}, 2'b00);
        end
        chk("mem_10", mem[8'h10], 16'hBEEF);
        chk("mem_00", mem[8'h00], 16'h1111);
        chk("mem_01", mem[8'h01], 16'h2222);
        chk("mem_ff", mem[8'hFF], 16'h1234);

        // reset during ACCESS of a write
        Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 8'h20; WData_A = 16'h5555;
        step();
        chk("rw_we_before", Mem_Write_EN, 1);
        chk("rw_busy_before", Busy, 1);
        #3;
        Reset_N = 1'b0;
        #1;
        chk("rw_we_async", Mem_Write_EN, 0);
        chk("rw_ack_async", Ack_A, 0);
        chk("rw_busy_async", Busy, 0);
        Req_A = 1'b0; Wr_A = 1'b0;
        step();
        Reset_N = 1'b1;
        step();
        chk("rw_discarded", mem[8'h20] == 16'h5555, 0);
        chk("rw_no_ack", {Ack_A, Ack_B, Busy}, 3'b000);

        // first contention after reset goes to A
        Req_A = 1'b1; Addr_A = 8'h00; Req_B = 1'b1; Wr_B = 1'b0; Addr_B = 8'h01;
        step();
        chk("post_rst_grant_addr", Mem_Address, 8'h00);
        step();
        chk("post_rst_acks", {Ack_A, Ack_B}, 2'b10);
        chk("post_rst_rd_a", RData_A, 16'h1111);
        Req_A = 1'b0; Req_B = 1'b0;
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
